spi_poll_ctrl: RTL and testbench

Scheduler for the 40-bit SPI frame receiver on the servo-steering path. It fires one receive transaction every POLL_CYCLES with a start/done handshake and supervises each transaction with a timeout. Each 5-byte frame is validated by header and XOR checksum. Only valid frames update the registered servo command outputs; failures feed an error counter and a link-health flag.

---
 rtl/spi_poll_pkg.sv | 38 +++
 rtl/spi_poll_ctrl_if.sv | 12 +
 rtl/spi_poll_ctrl_poll_timer.sv | 29 ++
 rtl/spi_poll_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_poll_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_poll_pkg.sv
// Shared types and frame layout for the polled SPI servo-command receiver.
package spi_poll_pkg;

  localparam int FRAME_BITS = 40;

  // Frame fields, MSB first: header, servo_x, servo_y, mode, checksum
  localparam int HDR_MSB  = 39;
  localparam int HDR_LSB  = 32;
  localparam int X_MSB    = 31;
  localparam int X_LSB    = 24;
  localparam int Y_MSB    = 23;
  localparam int Y_LSB    = 16;
  localparam int MODE_MSB = 15;
  localparam int MODE_LSB = 8;
  localparam int CSUM_MSB = 7;
  localparam int CSUM_LSB = 0;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_HDR     = 2'd2,
    ERR_CSUM    = 2'd3
  } err_t;

  function automatic logic [7:0] frame_csum(input logic [FRAME_BITS-1:0] f);
    return f[HDR_MSB:HDR_LSB] ^ f[X_MSB:X_LSB] ^ f[Y_MSB:Y_LSB] ^ f[MODE_MSB:MODE_LSB];
  endfunction

endpackage

// File: rtl/spi_poll_ctrl_if.sv
// Start/done handshake and frame bus between the poll controller and the SPI receiver.
interface spi_poll_ctrl_if;
  import spi_poll_pkg::*;

  logic                  spi_start;
  logic                  spi_done;
  logic [FRAME_BITS-1:0] spi_data;

  modport master (output spi_start, input spi_done, input spi_data);
  modport slave  (input spi_start, output spi_done, output spi_data);

endinterface

// File: rtl/spi_poll_ctrl_poll_timer.sv
// Free-running poll period timer; held at zero while disabled.
module poll_timer #(
  parameter int PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = $clog2(PERIOD);
  localparam logic [CW-1:0] TERM = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_r;

  // Period counter wrapping at terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (!enable || (cnt_r == TERM)) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = enable && (cnt_r == TERM);

endmodule

// File: rtl/spi_poll_ctrl.sv
// Polled SPI frame scheduler: one supervised receive per poll period; only
// header- and checksum-valid frames reach the registered servo outputs.
module spi_poll_ctrl
  import spi_poll_pkg::*;
#(
  parameter int         POLL_CYCLES    = 1_000_000,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] HEADER         = DEFAULT_HEADER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  spi_poll_ctrl_if.master spi,
  output logic [7:0]      servo_x,
  output logic [7:0]      servo_y,
  output logic [7:0]      servo_mode,
  output logic            cmd_valid,
  output logic            link_ok,
  output logic [1:0]      err_code,
  output logic [7:0]      err_cnt,
  output logic            overrun
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                state_r, state_nxt_s;
  err_t                  chk_err_s, fail_code_s, err_code_r;
  logic                  tick_s, capture_s, timeout_s, frame_ok_s, fail_s;
  logic [TW-1:0]         tmo_cnt_r;
  logic [FRAME_BITS-1:0] frame_r;
  logic [1:0]            streak_r;
  logic [7:0]            servo_x_r, servo_y_r, servo_mode_r, err_cnt_r;
  logic                  spi_start_r, cmd_valid_r, link_ok_r, overrun_r;

  poll_timer #(.PERIOD(POLL_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick_s)
  );

  // Next-state logic; spi_done wins over a same-cycle timeout
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick_s) state_nxt_s = START;
        else        state_nxt_s = IDLE;
      end
      START: state_nxt_s = WAIT;
      WAIT: begin
        if (spi.spi_done) begin
          state_nxt_s = CHECK;
          capture_s   = 1'b1;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s = IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      CHECK:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame validation (header has priority) and failure classification
  always_comb begin
    chk_err_s = ERR_NONE;
    if (frame_r[HDR_MSB:HDR_LSB] != HEADER) begin
      chk_err_s = ERR_HDR;
    end else if (frame_r[CSUM_MSB:CSUM_LSB] != frame_csum(frame_r)) begin
      chk_err_s = ERR_CSUM;
    end else begin
      chk_err_s = ERR_NONE;
    end
    fail_code_s = chk_err_s;
    if (timeout_s) fail_code_s = ERR_TIMEOUT;
    else           fail_code_s = chk_err_s;
  end

  assign frame_ok_s = (state_r == CHECK) && (chk_err_s == ERR_NONE);
  assign fail_s     = timeout_s || ((state_r == CHECK) && (chk_err_s != ERR_NONE));

  // Timeout counter: cleared in START, counts every WAIT cycle
  always_ff @(posedge clk) begin
    if (rst)                  tmo_cnt_r <= {TW{1'b0}};
    else if (state_r == START) tmo_cnt_r <= {TW{1'b0}};
    else if (state_r == WAIT)  tmo_cnt_r <= tmo_cnt_r + TW'(1);
    else                       tmo_cnt_r <= tmo_cnt_r;
  end

  // State, handshake, frame capture and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      spi_start_r  <= 1'b0;
      frame_r      <= {FRAME_BITS{1'b0}};
      servo_x_r    <= 8'd0;
      servo_y_r    <= 8'd0;
      servo_mode_r <= 8'd0;
      cmd_valid_r  <= 1'b0;
      link_ok_r    <= 1'b0;
      err_code_r   <= ERR_NONE;
      err_cnt_r    <= 8'd0;
      streak_r     <= 2'd0;
      overrun_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      spi_start_r <= (state_nxt_s == START);
      cmd_valid_r <= frame_ok_s;
      if (capture_s) frame_r <= spi.spi_data;
      // A tick outside IDLE is dropped, never queued
      if (tick_s && (state_r != IDLE)) overrun_r <= 1'b1;
      if (frame_ok_s) begin
        servo_x_r    <= frame_r[X_MSB:X_LSB];
        servo_y_r    <= frame_r[Y_MSB:Y_LSB];
        servo_mode_r <= frame_r[MODE_MSB:MODE_LSB];
        link_ok_r    <= 1'b1;
        err_code_r   <= ERR_NONE;
        streak_r     <= 2'd0;
      end else if (fail_s) begin
        err_code_r <= fail_code_s;
        if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
        if (streak_r != 2'd3)   streak_r  <= streak_r + 2'd1;
        if (streak_r >= 2'd2)   link_ok_r <= 1'b0;
      end
    end
  end

  assign spi.spi_start = spi_start_r;
  assign servo_x       = servo_x_r;
  assign servo_y       = servo_y_r;
  assign servo_mode    = servo_mode_r;
  assign cmd_valid     = cmd_valid_r;
  assign link_ok       = link_ok_r;
  assign err_code      = err_code_r;
  assign err_cnt       = err_cnt_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_spi_poll_ctrl.sv
// Self-checking bench for spi_poll_ctrl: transaction-level model compared every
// cycle, plus directed literal checks including a short-period overrun instance.
module tb_spi_poll_ctrl;

  localparam int P = 20;
  localparam int T = 41;
  localparam logic [7:0]  HDR    = 8'hA5;
  localparam logic [39:0] VALID1 = 40'hA5_10_20_03_96;
  localparam logic [39:0] VALID2 = 40'hA5_33_44_55_87;
  localparam logic [39:0] RACE   = 40'hA5_7F_80_01_5B;
  localparam logic [39:0] BADCS  = 40'hA5_10_20_03_00;
  localparam logic [39:0] BADHD  = 40'h5A_10_20_03_00;

  logic clk, rst, rst_b, en_a, en_b;
  logic [7:0] sx_a, sy_a, sm_a, cnt_a, sx_b, sy_b, sm_b, cnt_b;
  logic cv_a, link_a, ovr_a, cv_b, link_b, ovr_b;
  logic [1:0] err_a, err_b;

  int n_vec = 0;
  int n_mis = 0;
  bit model_ready = 1'b0;

  // Expected DUT A outputs for the current cycle
  logic       e_start, e_cv, e_link, e_ovr;
  logic [7:0] e_x, e_y, e_m, e_cnt;
  logic [1:0] e_err;
  int         m_fails;

  spi_poll_ctrl_if ifa ();
  spi_poll_ctrl_if ifb ();

  spi_poll_ctrl #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T), .HEADER(HDR)) dut (
    .clk(clk), .rst(rst), .enable(en_a), .spi(ifa.master),
    .servo_x(sx_a), .servo_y(sy_a), .servo_mode(sm_a), .cmd_valid(cv_a),
    .link_ok(link_a), .err_code(err_a), .err_cnt(cnt_a), .overrun(ovr_a)
  );

  spi_poll_ctrl #(.POLL_CYCLES(8), .TIMEOUT_CYCLES(10), .HEADER(HDR)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .spi(ifb.master),
    .servo_x(sx_b), .servo_y(sy_b), .servo_mode(sm_b), .cmd_valid(cv_b),
    .link_ok(link_b), .err_code(err_b), .err_cnt(cnt_b), .overrun(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic log_fail(input logic [1:0] code);
    e_err = code;
    if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
    if (m_fails < 3) m_fails++;
    if (m_fails == 3) e_link = 1'b0;
  endtask

  task automatic judge(input logic [39:0] f);
    if (f[39:32] != HDR) log_fail(2'd2);
    else if (f[7:0] != (f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8])) log_fail(2'd3);
    else begin
      e_x = f[31:24]; e_y = f[23:16]; e_m = f[15:8];
      e_cv = 1'b1; e_link = 1'b1; e_err = 2'd0; m_fails = 0;
    end
  endtask

  // Transaction-level model: tracks poll ticks, the busy window of each
  // transaction and the cycle at which its outcome becomes visible.
  initial begin : model_proc
    int tmr, cyc, s_cyc, end_cyc, pend_cyc;
    bit active, ended, pend_v, tick, idle;
    logic [39:0] pend_data;
    cyc = 0; tmr = 0; active = 0; ended = 0; pend_v = 0; m_fails = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        tmr = 0; active = 0; pend_v = 0; m_fails = 0;
        e_start = 1'b0; e_cv = 1'b0; e_link = 1'b0; e_ovr = 1'b0;
        e_x = 8'd0; e_y = 8'd0; e_m = 8'd0; e_cnt = 8'd0; e_err = 2'd0;
      end else begin
        tick = en_a && (tmr == P - 1);
        tmr  = en_a ? ((tmr == P - 1) ? 0 : tmr + 1) : 0;
        idle = !active || (ended && cyc > end_cyc);
        if (idle) active = 0;
        e_start = 1'b0;
        e_cv    = 1'b0;
        if (pend_v && pend_cyc == cyc + 1) begin
          pend_v = 0;
          judge(pend_data);
        end
        if (active && !ended && cyc > s_cyc) begin
          if (ifa.spi_done) begin
            pend_v = 1; pend_cyc = cyc + 2; pend_data = ifa.spi_data;
            ended = 1; end_cyc = cyc + 1;
          end else if (cyc == s_cyc + T) begin
            log_fail(2'd1);
            ended = 1; end_cyc = cyc;
          end
        end
        if (tick) begin
          if (idle) begin
            active = 1; ended = 0; s_cyc = cyc + 1; e_start = 1'b1;
          end else begin
            e_ovr = 1'b1;
          end
        end
      end
      cyc++;
      model_ready = 1'b1;
    end
  end

  // Per-cycle comparison of DUT A against the model
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (model_ready) begin
        cmp("spi_start", {7'd0, ifa.spi_start}, {7'd0, e_start});
        cmp("cmd_valid", {7'd0, cv_a}, {7'd0, e_cv});
        cmp("link_ok", {7'd0, link_a}, {7'd0, e_link});
        cmp("overrun", {7'd0, ovr_a}, {7'd0, e_ovr});
        cmp("err_code", {6'd0, err_a}, {6'd0, e_err});
        cmp("err_cnt", cnt_a, e_cnt);
        cmp("servo_x", sx_a, e_x);
        cmp("servo_y", sy_a, e_y);
        cmp("servo_mode", sm_a, e_m);
      end
    end
  end

  task automatic wait_start();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!ifa.spi_start && w < 100);
    if (!ifa.spi_start) begin
      n_vec++; n_mis++;
      $display("FAIL start_wait: no spi_start after %0d cycles, expected one", w);
    end
  endtask

  // k=0: no spi_done, return in the cycle the timeout becomes visible;
  // k>0: spi_done in WAIT cycle k, return in the cycle results become visible.
  task automatic serve(input int k, input logic [39:0] f);
    wait_start();
    if (k == 0) begin
      repeat (T + 1) @(negedge clk);
    end else begin
      repeat (k) @(negedge clk);
      ifa.spi_done = 1'b1; ifa.spi_data = f;
      @(negedge clk);
      ifa.spi_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin : stim_proc
    int starts;
    rst = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b1;
    ifa.spi_done = 1'b0; ifa.spi_data = 40'd0;
    ifb.spi_done = 1'b0; ifb.spi_data = 40'd0;
    repeat (3) @(negedge clk);
    cmp("rst_spi_start", {7'd0, ifa.spi_start}, 8'h00);
    cmp("rst_link_ok", {7'd0, link_a}, 8'h00);
    cmp("rst_err_cnt", cnt_a, 8'h00);
    cmp("rst_overrun", {7'd0, ovr_a}, 8'h00);

    // Short-period instance: stalled receiver causes timeouts and overrun
    rst_b = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      case (k)
        12: begin cmp("b_ovr_c12", {7'd0, ovr_b}, 8'h00); cmp("b_cnt_c12", cnt_b, 8'h00); end
        15: cmp("b_ovr_c15", {7'd0, ovr_b}, 8'h00);
        16: cmp("b_ovr_c16", {7'd0, ovr_b}, 8'h01);
        18: cmp("b_cnt_c18", cnt_b, 8'h00);
        19: begin cmp("b_cnt_c19", cnt_b, 8'h01); cmp("b_err_c19", {6'd0, err_b}, 8'h01); end
        38: begin cmp("b_cnt_c38", cnt_b, 8'h02); cmp("b_ovr_c38", {7'd0, ovr_b}, 8'h01); end
        default: ;
      endcase
    end

    rst = 1'b0; en_a = 1'b1;
    serve(3, VALID1);
    cmp("v1_cmd_valid", {7'd0, cv_a}, 8'h01);
    cmp("v1_servo_x", sx_a, 8'h10);
    cmp("v1_servo_y", sy_a, 8'h20);
    cmp("v1_servo_mode", sm_a, 8'h03);
    cmp("v1_link_ok", {7'd0, link_a}, 8'h01);
    cmp("v1_err_code", {6'd0, err_a}, 8'h00);

    serve(2, BADCS);
    cmp("cs_err_code", {6'd0, err_a}, 8'h03);
    cmp("cs_err_cnt", cnt_a, 8'h01);
    cmp("cs_cmd_valid", {7'd0, cv_a}, 8'h00);
    cmp("cs_servo_x", sx_a, 8'h10);

    serve(4, BADHD);
    cmp("hd_err_code", {6'd0, err_a}, 8'h02);
    cmp("hd_err_cnt", cnt_a, 8'h02);

    serve(T, RACE);
    cmp("race_cmd_valid", {7'd0, cv_a}, 8'h01);
    cmp("race_servo_x", sx_a, 8'h7F);
    cmp("race_err_code", {6'd0, err_a}, 8'h00);
    cmp("race_err_cnt", cnt_a, 8'h02);

    pulse_rst();
    serve(1, VALID1);
    for (int i = 1; i <= 3; i++) begin
      serve(0, 40'd0);
      cmp("to_err_code", {6'd0, err_a}, 8'h01);
      cmp("to_err_cnt", cnt_a, 8'(i));
      cmp("to_link_ok", {7'd0, link_a}, (i < 3) ? 8'h01 : 8'h00);
    end
    serve(1, VALID1);
    cmp("relink_ok", {7'd0, link_a}, 8'h01);

    pulse_rst();
    repeat (260) serve(1, BADHD);
    cmp("sat_err_cnt", cnt_a, 8'hFF);
    cmp("sat_link_ok", {7'd0, link_a}, 8'h00);

    // Enable dropped mid-transaction: it completes, then no new polls
    wait_start();
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    ifa.spi_done = 1'b1; ifa.spi_data = VALID2;
    @(negedge clk);
    ifa.spi_done = 1'b0;
    @(negedge clk);
    cmp("en_cmd_valid", {7'd0, cv_a}, 8'h01);
    cmp("en_servo_mode", sm_a, 8'h55);
    starts = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (ifa.spi_start) starts++;
    end
    cmp("en_no_restart", 8'(starts), 8'h00);

    // Reset during WAIT, then a late spi_done
    en_a = 1'b1;
    wait_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("rw_servo_x", sx_a, 8'h00);
    cmp("rw_link_ok", {7'd0, link_a}, 8'h00);
    cmp("rw_err_cnt", cnt_a, 8'h00);
    cmp("rw_overrun", {7'd0, ovr_a}, 8'h00);
    cmp("rw_spi_start", {7'd0, ifa.spi_start}, 8'h00);
    rst = 1'b0; en_a = 1'b0;
    @(negedge clk);
    ifa.spi_done = 1'b1; ifa.spi_data = VALID1;
    @(negedge clk);
    ifa.spi_done = 1'b0;
    repeat (3) @(negedge clk);
    cmp("late_servo_x", sx_a, 8'h00);
    cmp("late_err_cnt", cnt_a, 8'h00);
    cmp("late_link_ok", {7'd0, link_a}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
